data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder side of the core's data-memory port: serves ce/we/addr/wdata from the single-cycle core
//  with a same-cycle read path and clocked writes. Decodes word RAM plus an MMIO window holding a
//  console TX FIFO (drained over valid/ready) and a free-running cycle timer. Sits at top level beside
//  the core, wired to its data_* ports.
// PARAMETERS
//  WORD_BITWIDTH    32            data/address width
//  RAM_DEPTH_WORDS  1024          RAM size in 32-bit words (power of 2)
//  FIFO_DEPTH       8             TX FIFO entries (power of 2, >=2)
//  MMIO_BASE        32'h1000_0000 base of MMIO window (16 bytes)
// PORTS
//  clk       in   1   clock, all state on rising edge
//  rst_n     in   1   reset; synchronous, active-low
//  ce_i      in   1   access enable from core
//  we_i      in   1   1=write, 0=read (qualified by ce_i)
//  addr_i    in   32  byte address; addr_i[1:0] ignored (word access only)
//  wdata_i   in   32  store data
//  rdata_o   out  32  load data, combinational from addr_i
//  tx_valid  out  1   FIFO head valid
//  tx_data   out  8   FIFO head byte
//  tx_ready  in   1   sink accepts head when tx_valid&tx_ready
//  bus_err   out  1   sticky: access to unmapped address
// BEHAVIOUR
//  Decode: RAM if addr_i < RAM_DEPTH_WORDS*4; MMIO if addr_i[31:4]==MMIO_BASE[31:4]; else unmapped.
//  MMIO offsets: 0x0 TXDATA (W: push wdata_i[7:0]; R: 0); 0x4 STATUS (R: [0]full [1]empty [2]overflow
//   [15:8]count; W: wdata_i[2]=1 clears overflow); 0x8 TIMER (R: value; W: load); 0xC reserved (R 0, W ignored).
//  Read: rdata_o valid same cycle, zero latency; rdata_o=0 when ce_i=0, we_i=1, or unmapped.
//  Write: takes effect at the rising edge where ce_i&we_i; RAM read of same address that cycle returns old data.
//  Reset (rst_n=0 at edge): FIFO empty (tx_valid=0, tx_data=0), count=0, overflow=0, timer=0, bus_err=0.
//   RAM array not cleared. Reset mid-operation discards FIFO contents and any same-cycle write.
//  FIFO: pop on tx_valid&tx_ready. Push on TXDATA write accepted if !full, or if full and pop same cycle.
//   Push rejected when full without pop: data dropped, overflow<=1 (sticky until cleared or reset).
//   Simultaneous push+pop: count unchanged; empty+push: tx_valid rises next cycle (no bypass).
//   Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits, zero-extended into STATUS[15:8].
//   tx_data stable while tx_valid&!tx_ready.
//  Overflow set and clear same cycle: set wins.
//  Timer: +1 every cycle out of reset, wraps 32'hFFFF_FFFF->0; TIMER write loads wdata_i (load wins over increment).
//  bus_err<=1 on any ce_i access (read or write) to unmapped address; cleared only by reset.
//  ce_i=0: no side effects regardless of we_i/addr_i.
// STRUCTURE
//  Shared include mem/mem_map.vh: MMIO_BASE default, offsets TXDATA/STATUS/TIMER, STATUS bit indices.
//  One sub-module: sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count). RAM, decode, timer inline.
// TESTING
//  1 RAM: write 0xDEADBEEF @0x40, read 0x40 next cycle -> 0xDEADBEEF; read 0x42 -> same word.
//  2 FIFO fill: tx_ready=0, write 0x41..0x49 to TXDATA (9 pushes, depth 8) -> STATUS=0x0000_0805
//    (count 8, full, overflow); drain -> bytes 0x41..0x48 in order, empty=1, 0x49 never seen.
//  3 Full with simultaneous push+pop: count stays 8, overflow stays 0, new byte emerges last.
//  4 Timer: write 0xFFFF_FFFE, read next cycle -> 0xFFFF_FFFF, following cycle -> 0x0000_0000.
//  5 Unmapped: read 0x2000_0000 -> rdata_o=0, bus_err=1 next cycle; ce_i=0 same address -> no bus_err.
//  6 Reset mid-drain: 3 bytes queued, rst_n low one cycle -> tx_valid=0, STATUS=0x0000_0002, timer 0; RAM @0x40 retained.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: MMIO register map, STATUS layout, decode regions.
package data_mem_responder_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1000_0000;

    // Word offset within the 16-byte MMIO window, taken from addr_i[3:2]
    typedef enum logic [1:0] {
        MMIO_TXDATA = 2'd0,
        MMIO_STATUS = 2'd1,
        MMIO_TIMER  = 2'd2,
        MMIO_RSVD   = 2'd3
    } mmio_reg_e;

    typedef enum logic [1:0] {
        REGION_RAM  = 2'd0,
        REGION_MMIO = 2'd1,
        REGION_NONE = 2'd2
    } region_e;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_COUNT_LSB = 8;
    localparam int STATUS_COUNT_W   = 8;

endpackage

// File: rtl/data_mem_responder_sync_fifo.sv
// Synchronous FIFO with registered head; a push into a full FIFO is taken only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // Head reads as zero when empty so tx_data is clean after reset
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus MMIO window (console TX FIFO, STATUS, cycle timer).
// Reads are combinational from addr_i; all writes land on the rising edge.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int                 WORD_BITWIDTH   = 32,
    parameter int                 RAM_DEPTH_WORDS = 1024,
    parameter int                 FIFO_DEPTH      = 8,
    parameter logic [31:0]        MMIO_BASE       = MMIO_BASE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce_i,
    input  logic                     we_i,
    input  logic [WORD_BITWIDTH-1:0] addr_i,
    input  logic [WORD_BITWIDTH-1:0] wdata_i,
    output logic [WORD_BITWIDTH-1:0] rdata_o,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    input  logic                     tx_ready,
    output logic                     bus_err
);

    localparam int RAM_AW = $clog2(RAM_DEPTH_WORDS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [WORD_BITWIDTH-1:0] RAM_BYTES = WORD_BITWIDTH'(RAM_DEPTH_WORDS * 4);

    logic [WORD_BITWIDTH-1:0] ram_q [RAM_DEPTH_WORDS];
    logic [WORD_BITWIDTH-1:0] timer_q, timer_d;
    logic                     overflow_q, overflow_d;
    logic                     bus_err_q, bus_err_d;

    region_e                  region;
    mmio_reg_e                mmio_sel;
    logic [RAM_AW-1:0]        ram_idx;
    logic                     wr_acc;
    logic                     rd_acc;
    logic                     ram_we;
    logic                     tx_push;
    logic                     tx_pop;
    logic                     status_wr;
    logic                     timer_wr;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CNT_W-1:0]         fifo_count;
    logic [WORD_BITWIDTH-1:0] status_word;
    logic                     unused_addr_lsb;

    assign unused_addr_lsb = ^addr_i[1:0];

    always_comb begin
        region = REGION_NONE;
        if (addr_i < RAM_BYTES) begin
            region = REGION_RAM;
        end else if (addr_i[WORD_BITWIDTH-1:4] == MMIO_BASE[WORD_BITWIDTH-1:4]) begin
            region = REGION_MMIO;
        end
    end

    assign mmio_sel  = mmio_reg_e'(addr_i[3:2]);
    assign ram_idx   = addr_i[RAM_AW+1:2];
    assign wr_acc    = ce_i & we_i;
    assign rd_acc    = ce_i & ~we_i;
    assign ram_we    = wr_acc && (region == REGION_RAM);
    assign tx_push   = wr_acc && (region == REGION_MMIO) && (mmio_sel == MMIO_TXDATA);
    assign status_wr = wr_acc && (region == REGION_MMIO) && (mmio_sel == MMIO_STATUS);
    assign timer_wr  = wr_acc && (region == REGION_MMIO) && (mmio_sel == MMIO_TIMER);
    assign tx_pop    = tx_valid & tx_ready;
    assign tx_valid  = ~fifo_empty;
    assign bus_err   = bus_err_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .data_i  (wdata_i[7:0]),
        .data_o  (tx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // A rejected push and an overflow clear in the same cycle leave overflow set
    always_comb begin
        overflow_d = overflow_q;
        if (status_wr && wdata_i[STATUS_OVF_BIT]) begin
            overflow_d = 1'b0;
        end
        if (tx_push && fifo_full && !tx_pop) begin
            overflow_d = 1'b1;
        end
        timer_d   = timer_wr ? wdata_i : timer_q + 1'b1;
        bus_err_d = bus_err_q | (ce_i && (region == REGION_NONE));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q    <= '0;
            overflow_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            overflow_q <= overflow_d;
            bus_err_q  <= bus_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && ram_we) begin
            ram_q[ram_idx] <= wdata_i;
        end
    end

    always_comb begin
        status_word = '0;
        status_word[STATUS_FULL_BIT]  = fifo_full;
        status_word[STATUS_EMPTY_BIT] = fifo_empty;
        status_word[STATUS_OVF_BIT]   = overflow_q;
        status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);
    end

    always_comb begin
        rdata_o = '0;
        if (rd_acc) begin
            case (region)
                REGION_RAM: rdata_o = ram_q[ram_idx];
                REGION_MMIO: begin
                    case (mmio_sel)
                        MMIO_STATUS: rdata_o = status_word;
                        MMIO_TIMER:  rdata_o = timer_q;
                        default:     rdata_o = '0;
                    endcase
                end
                default: rdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus queues expectations, a negedge monitor checks them.
module tb_data_mem_responder;

    localparam logic [31:0] A_TXDATA = 32'h1000_0000;
    localparam logic [31:0] A_STATUS = 32'h1000_0004;
    localparam logic [31:0] A_TIMER  = 32'h1000_0008;
    localparam logic [31:0] A_RSVD   = 32'h1000_000C;

    localparam int SEL_RDATA   = 0;
    localparam int SEL_BUSERR  = 1;
    localparam int SEL_TXVALID = 2;
    localparam int SEL_TXDATA  = 3;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        bus_err;

    chk_t        chk_q[$];
    logic [7:0]  tx_q[$];
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce_i     (ce_i),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .rdata_o  (rdata_o),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .bus_err  (bus_err)
    );

    // Monitor: checks queued expectations and every byte leaving the TX port
    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            chk_t        c;
            logic [31:0] act;
            c = chk_q.pop_front();
            case (c.sel)
                SEL_RDATA:   act = rdata_o;
                SEL_BUSERR:  act = {31'b0, bus_err};
                SEL_TXVALID: act = {31'b0, tx_valid};
                default:     act = {24'b0, tx_data};
            endcase
            n_tests++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
        if (rst_n && tx_valid && tx_ready) begin
            n_tests++;
            if (tx_q.size() == 0) begin
                n_fail++;
                $display("FAIL tx_unexpected: got byte %h expected none", tx_data);
            end else begin
                logic [7:0] e;
                e = tx_q.pop_front();
                if (tx_data !== e) begin
                    n_fail++;
                    $display("FAIL tx_byte: got %h expected %h", tx_data, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string name, input int sel, input logic [31:0] v);
        chk_q.push_back('{name, sel, v});
    endtask

    task automatic drive(input logic ce, input logic we, input logic [31:0] a, input logic [31:0] d);
        ce_i = ce;
        we_i = we;
        addr_i = a;
        wdata_i = d;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, 1'b1, a, d);
        step();
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b1, 1'b0, a, 32'h0);
        expect_val(name, SEL_RDATA, exp);
        step();
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (n) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(2);
        rst_n = 1'b1;

        // Reset state
        expect_val("rst_tx_valid", SEL_TXVALID, 32'h0);
        expect_val("rst_tx_data", SEL_TXDATA, 32'h0);
        expect_val("rst_bus_err", SEL_BUSERR, 32'h0);
        rd("rst_timer", A_TIMER, 32'h0);
        rd("rst_status", A_STATUS, 32'h0000_0002);

        // RAM write/read, byte-offset alias, zero rdata on write and on ce=0
        wr(32'h40, 32'hDEAD_BEEF);
        rd("ram_rd", 32'h40, 32'hDEAD_BEEF);
        rd("ram_rd_unaligned", 32'h42, 32'hDEAD_BEEF);
        drive(1'b1, 1'b1, 32'h48, 32'h1234_5678);
        expect_val("rdata_on_write", SEL_RDATA, 32'h0);
        step();
        drive(1'b0, 1'b0, 32'h40, 32'h0);
        expect_val("rdata_ce0", SEL_RDATA, 32'h0);
        step();
        drive(1'b0, 1'b1, 32'h40, 32'h5555_AAAA);
        step();
        rd("ram_ce0_no_write", 32'h40, 32'hDEAD_BEEF);
        rd("ram_rd_48", 32'h48, 32'h1234_5678);
        rd("txdata_reads_zero", A_TXDATA, 32'h0);
        rd("rsvd_reads_zero", A_RSVD, 32'h0);

        // FIFO fill past depth, then drain
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr(A_TXDATA, 32'h41 + 32'(i));
            if (i < 8) tx_q.push_back(8'(8'h41 + i));
        end
        expect_val("full_tx_valid", SEL_TXVALID, 32'h1);
        expect_val("full_tx_head", SEL_TXDATA, 32'h41);
        rd("status_full_ovf", A_STATUS, 32'h0000_0805);
        tx_ready = 1'b1;
        idle(8);
        tx_ready = 1'b0;
        expect_val("drained_tx_valid", SEL_TXVALID, 32'h0);
        rd("status_drained_ovf", A_STATUS, 32'h0000_0006);
        wr(A_STATUS, 32'h0000_0004);
        rd("status_ovf_cleared", A_STATUS, 32'h0000_0002);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            wr(A_TXDATA, 32'h50 + 32'(i));
            tx_q.push_back(8'(8'h50 + i));
        end
        tx_ready = 1'b1;
        tx_q.push_back(8'h58);
        wr(A_TXDATA, 32'h58);
        tx_ready = 1'b0;
        rd("status_full_pushpop", A_STATUS, 32'h0000_0801);
        tx_ready = 1'b1;
        idle(8);
        tx_ready = 1'b0;
        rd("status_after_drain2", A_STATUS, 32'h0000_0002);

        // Timer load and wrap
        wr(A_TIMER, 32'hFFFF_FFFE);
        idle(1);
        rd("timer_max", A_TIMER, 32'hFFFF_FFFF);
        rd("timer_wrap", A_TIMER, 32'h0000_0000);

        // Unmapped access
        drive(1'b0, 1'b0, 32'h2000_0000, 32'h0);
        step();
        drive(1'b0, 1'b1, 32'h2000_0000, 32'h0);
        step();
        expect_val("bus_err_ce0", SEL_BUSERR, 32'h0);
        rd("unmapped_rdata", 32'h2000_0000, 32'h0);
        expect_val("bus_err_set", SEL_BUSERR, 32'h1);
        idle(1);
        expect_val("bus_err_sticky", SEL_BUSERR, 32'h1);
        idle(1);

        // Reset mid-operation with a same-cycle RAM write
        for (int i = 0; i < 3; i++) wr(A_TXDATA, 32'h61 + 32'(i));
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 32'h40, 32'h0BAD_F00D);
        step();
        rst_n = 1'b1;
        expect_val("rst2_tx_valid", SEL_TXVALID, 32'h0);
        expect_val("rst2_tx_data", SEL_TXDATA, 32'h0);
        expect_val("rst2_bus_err", SEL_BUSERR, 32'h0);
        rd("rst2_timer", A_TIMER, 32'h0);
        rd("rst2_status", A_STATUS, 32'h0000_0002);
        rd("rst2_ram_kept", 32'h40, 32'hDEAD_BEEF);
        tx_ready = 1'b1;
        idle(3);
        tx_ready = 1'b0;
        idle(1);

        n_tests++;
        if (tx_q.size() != 0) begin
            n_fail++;
            $display("FAIL tx_leftover: got %0d pending expected 0", tx_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
